// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: function codes, ALU control
// encodings, FSM states and a helper that flags signed-overflow-reporting functions.
package alu_issue_pkg;

  localparam logic [2:0] FUNC_AND  = 3'b000;
  localparam logic [2:0] FUNC_OR   = 3'b001;
  localparam logic [2:0] FUNC_ADD  = 3'b010;
  localparam logic [2:0] FUNC_SUB  = 3'b011;
  localparam logic [2:0] FUNC_SLT  = 3'b100;
  localparam logic [2:0] FUNC_NOR  = 3'b101;
  localparam logic [2:0] FUNC_MUL  = 3'b110;
  localparam logic [2:0] FUNC_RSVD = 3'b111;

  localparam logic [1:0] ALU_OP_AND = 2'b00;
  localparam logic [1:0] ALU_OP_OR  = 2'b01;
  localparam logic [1:0] ALU_OP_ADD = 2'b10;
  localparam logic [1:0] ALU_OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Only the adder-based functions report a meaningful signed overflow.
  function automatic logic func_has_ovf(input logic [2:0] f);
    return (f == FUNC_ADD) || (f == FUNC_SUB) || (f == FUNC_SLT);
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Combinational decode of a function code into the ripple ALU's Ainvert/Binvert/op.
// MUL maps to ADD (used per iteration); reserved maps to AND.
module alu_func_decode
  import alu_issue_pkg::*;
(
  input  logic [2:0] func,
  output logic       ainvert,
  output logic       binvert,
  output logic [1:0] op
);

  always_comb begin
    ainvert = 1'b0;
    binvert = 1'b0;
    op      = ALU_OP_AND;
    case (func)
      FUNC_AND: op = ALU_OP_AND;
      FUNC_OR:  op = ALU_OP_OR;
      FUNC_ADD: op = ALU_OP_ADD;
      FUNC_SUB: begin
        binvert = 1'b1;
        op      = ALU_OP_ADD;
      end
      FUNC_SLT: begin
        binvert = 1'b1;
        op      = ALU_OP_SLT;
      end
      FUNC_NOR: begin
        ainvert = 1'b1;
        binvert = 1'b1;
        op      = ALU_OP_AND;
      end
      FUNC_MUL: op = ALU_OP_ADD;
      default:  op = ALU_OP_AND;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side controller for the external 8-bit ripple ALU: single-cycle ops and shift-add MUL.
// Optional sticky overflow flag with clear input when ALU_ISSUE_STICKY_OVF_EN is defined.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MUL_ITER = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_func,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_ainvert,
  output logic              alu_binvert,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow
`ifdef ALU_ISSUE_STICKY_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              ovf_sticky
`endif
);

  localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  state_t            state, state_nxt;
  logic [2:0]        func_q;
  logic [2:0]        func_sel;
  // mcand/mplier double as the latched A/B operands for single-cycle ops.
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mul_last;
  logic              capture_ovf;

  alu_func_decode u_decode (
    .func    (func_sel),
    .ainvert (alu_ainvert),
    .binvert (alu_binvert),
    .op      (alu_op)
  );

  assign mul_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    func_sel  = FUNC_RSVD;
    alu_src1  = '0;
    alu_src2  = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_func == FUNC_MUL) ? MUL : EXEC;
      end
      EXEC: begin
        func_sel = func_q;
        if (func_q != FUNC_RSVD) begin
          alu_src1 = mcand_q;
          alu_src2 = mplier_q;
        end
        state_nxt = RESP;
      end
      MUL: begin
        func_sel = FUNC_MUL;
        alu_src1 = acc_q;
        alu_src2 = mplier_q[0] ? mcand_q : '0;
        if (mul_last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign capture_ovf = (state == EXEC) && func_has_ovf(func_q) && alu_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      func_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            func_q   <= cmd_func;
            mcand_q  <= cmd_a;
            mplier_q <= cmd_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        EXEC: begin
          if (func_q == FUNC_RSVD) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_ovf    <= 1'b0;
          end else begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_ovf    <= capture_ovf;
          end
        end
        MUL: begin
          acc_q    <= alu_result;
          mcand_q  <= {mcand_q[DATA_W-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (mul_last) begin
            rsp_result <= alu_result;
            rsp_zero   <= (alu_result == '0);
            rsp_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_STICKY_OVF_EN
  // A new overflow capture beats a clear issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)           ovf_sticky <= 1'b0;
    else if (capture_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)     ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ripple-ALU model and a response scoreboard.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_func;
  logic [7:0] cmd_a, cmd_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_ovf;
  logic [7:0] alu_src1, alu_src2, alu_result;
  logic       alu_ainvert, alu_binvert, alu_zero, alu_overflow;
  logic [1:0] alu_op;
`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic       ovf_clr;
  logic       ovf_sticky;
`endif

  alu_issue_ctrl #(.DATA_W(8), .MUL_ITER(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_func     (cmd_func),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_ovf      (rsp_ovf),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ainvert  (alu_ainvert),
    .alu_binvert  (alu_binvert),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
`ifdef ALU_ISSUE_STICKY_OVF_EN
    ,
    .ovf_clr      (ovf_clr),
    .ovf_sticky   (ovf_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external 8-bit ripple ALU.
  logic [7:0] a_eff, b_eff;
  logic [8:0] sum9;
  logic       c_msb_in;
  always_comb begin
    a_eff        = alu_ainvert ? ~alu_src1 : alu_src1;
    b_eff        = alu_binvert ? ~alu_src2 : alu_src2;
    sum9         = {1'b0, a_eff} + {1'b0, b_eff} + {8'd0, alu_binvert};
    c_msb_in     = a_eff[7] ^ b_eff[7] ^ sum9[7];
    alu_overflow = c_msb_in ^ sum9[8];
    case (alu_op)
      2'b00:   alu_result = a_eff & b_eff;
      2'b01:   alu_result = a_eff | b_eff;
      2'b10:   alu_result = sum9[7:0];
      default: alu_result = {7'd0, sum9[7] ^ alu_overflow};
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       o;
    int         lat;
    int         acc;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: pops on each completed handshake; checks hold-stability under backpressure.
  logic       prev_valid = 1'b0;
  int         first_cyc  = 0;
  logic       hold_pend  = 1'b0;
  logic [9:0] hold_val;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (!prev_valid) first_cyc = cyc;
      if (hold_pend) chk("hold_stable", {22'd0, rsp_result, rsp_zero, rsp_ovf}, {22'd0, hold_val});
      if (rsp_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.tag, "_result"}, {24'd0, rsp_result}, {24'd0, e.res});
          chk({e.tag, "_zero"},   {31'd0, rsp_zero},   {31'd0, e.z});
          chk({e.tag, "_ovf"},    {31'd0, rsp_ovf},    {31'd0, e.o});
          chk({e.tag, "_latency"}, first_cyc + 1 - e.acc, e.lat);
        end
      end else begin
        hold_pend = 1'b1;
        hold_val  = {rsp_result, rsp_zero, rsp_ovf};
      end
    end else begin
      hold_pend = 1'b0;
    end
    prev_valid = rst_n && rsp_valid;
  end

  task automatic issue(input string tag, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ez, input logic eo, input int elat, input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_func  = f;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk({tag, "_accept_timeout"}, 32'd1, 32'd0);
    e.res = er; e.z = ez; e.o = eo; e.lat = elat; e.acc = cyc + 1; e.tag = tag;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_func  = 3'd0;
    cmd_a     = 8'd0;
    cmd_b     = 8'd0;
    rsp_ready = 1'b1;
`ifdef ALU_ISSUE_STICKY_OVF_EN
    ovf_clr   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_flags", {22'd0, rsp_result, rsp_zero, rsp_ovf}, 32'd0);
    chk("rst_alu_idle", {14'd0, alu_src1, alu_src2, alu_ainvert, alu_binvert}, 32'd0);
`ifdef ALU_ISSUE_STICKY_OVF_EN
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
`endif
    rst_n = 1'b1;

    issue("add_ovf",  3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 2, 1'b1);
    drain();
`ifdef ALU_ISSUE_STICKY_OVF_EN
    chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);
`endif
    issue("sub_zero", 3'b011, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 2, 1'b1);
    issue("nor",      3'b101, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 2, 1'b1);
    issue("slt_neg",  3'b100, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 2, 1'b1);
    issue("slt_pos",  3'b100, 8'h01, 8'h80, 8'h00, 1'b1, 1'b1, 2, 1'b1);
    issue("and",      3'b000, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 2, 1'b1);
    issue("rsvd",     3'b111, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 2, 1'b1);
    issue("mul_13x11", 3'b110, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 9, 1'b1);
    issue("mul_20x20", 3'b110, 8'd20, 8'd20, 8'h90, 1'b0, 1'b0, 9, 1'b1);
    issue("mul_zero",  3'b110, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 9, 1'b1);
    drain();

    // Backpressure: hold the response, keep a command waiting.
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue("bp_or", 3'b001, 8'hC0, 8'h05, 8'hC5, 1'b0, 1'b0, 2, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    cmd_func  = 3'b010;
    cmd_a     = 8'h10;
    cmd_b     = 8'h20;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    issue("bp_add", 3'b010, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 2, 1'b1);
    drain();

    // Reset in the middle of a multiply: no response may appear.
    issue("mul_rst", 3'b110, 8'd13, 8'd11, 8'h00, 1'b0, 1'b0, 9, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_regs", {22'd0, rsp_result, rsp_zero, rsp_ovf}, 32'd0);
    chk("midrst_alu_src", {16'd0, alu_src1, alu_src2}, 32'd0);
    issue("add_post_rst", 3'b010, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 2, 1'b1);
    drain();
`ifdef ALU_ISSUE_STICKY_OVF_EN
    chk("sticky_stays_clr", {31'd0, ovf_sticky}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d passed expected %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-side controller that drives the 8-bit ripple ALU (src1/src2, Ainvert, Binvert, op) and collects its result/zero/overflow.
- Accepts function-coded commands over a valid/ready handshake and decodes them to ALU control.
- Sequences single-cycle ops and an 8-iteration shift-add multiply through the same ALU.
- Returns registered responses over a second valid/ready handshake; sits between the datapath issue stage and the ALU instance.

Parameters:
DATA_W, 8, operand/result width; must equal ALU width
MUL_ITER, 8, multiply iterations; must equal DATA_W

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_func  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 reserved
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_W  result
rsp_zero  out  1  result == 0
rsp_ovf  out  1  signed overflow (ADD/SUB/SLT only)
alu_src1  out  DATA_W  to ALU_src1
alu_src2  out  DATA_W  to ALU_src2
alu_ainvert  out  1  to Ainvert
alu_binvert  out  1  to Binvert
alu_op  out  2  to op
alu_result  in  DATA_W  from ALU result
alu_zero  in  1  from ALU zero
alu_overflow  in  1  from ALU overflow

Behaviour:
- Decode {Ainvert,Binvert,op}:
  - AND 0,0,00; OR 0,0,01; ADD 0,0,10; SUB 0,1,10; SLT 0,1,11; NOR 1,1,00.
  - MUL iterations use ADD.
  - Reserved and idle states drive AND with zero operands.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch func/a/b.
  - Go to MUL if func=110, else EXEC.
- EXEC (1 cycle):
  - ALU driven from latched operands.
  - Result, zero and overflow captured into response regs at the cycle's end; then RESP.
  - Reserved func captures result=0, zero=1, ovf=0.
- MUL:
  - Regs: acc (cleared at accept), mcand=a, mplier=b, iteration counter 0..MUL_ITER-1.
  - Each cycle the ALU computes acc + (mplier[0] ? mcand : 0), and acc takes alu_result.
  - mcand shifts left 1 (zero fill), mplier shifts right 1.
  - Exactly MUL_ITER cycles; on the last, capture acc' and go to RESP.
  - Result is the low DATA_W bits of the unsigned product.
  - rsp_zero = (result==0); rsp_ovf=0; intermediate alu_overflow ignored.
- RESP:
  - rsp_valid=1; outputs stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE.
  - No bypass: cmd_ready is 0 outside IDLE, so no command is accepted in the handoff cycle.
- Latency:
  - Single-cycle op: rsp_valid is asserted 2 cycles after the accept edge.
  - MUL: MUL_ITER+1 cycles after the accept edge.
- Throughput: at most one command in flight.
- Reset (including mid-EXEC/MUL/RESP) forces:
  - state IDLE, cmd_ready=1, rsp_valid=0;
  - rsp_result=0, rsp_zero=0, rsp_ovf=0;
  - all operand/acc/counter regs to 0.
  - The in-flight command is discarded without a response.
- Simultaneous rsp_ready and cmd_valid in RESP: the response completes; the command waits for IDLE.

Optional Feature:
- Macro: ALU_ISSUE_STICKY_OVF_EN.
- Defined:
  - Adds ports ovf_clr (in, 1) and ovf_sticky (out, 1).
  - ovf_sticky sets when a response is captured with rsp_ovf=1.
  - ovf_sticky clears on ovf_clr; a set in the same cycle wins over the clear.
  - Reset value 0.
- Undefined: ports absent; no sticky register.

Decomposition:
- Package alu_issue_pkg:
  - func code localparams (FUNC_AND..FUNC_MUL, FUNC_RSVD);
  - ALU control encodings;
  - FSM state enum.
- One natural sub-module, alu_func_decode: combinational func to {Ainvert,Binvert,op}.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- ADD a=0x7F, b=0x01 -> result 0x80, ovf=1, zero=0; rsp_valid 2 cycles after accept.
- SUB a=0x05, b=0x05 -> result 0x00, zero=1, ovf=0. NOR a=0x0F, b=0xF0 -> 0x00, zero=1.
- SLT a=0x80 (-128), b=0x01 -> result 0x01. SLT a=0x01, b=0x80 -> result 0x00 (overflow-corrected less).
- MUL a=13, b=11 -> 0x8F after 9 cycles. MUL a=20, b=20 -> 0x90. MUL a=0, b=0xFF -> 0x00, zero=1.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> outputs stable, cmd_ready=0; new cmd accepted only after return to IDLE.
- Reset asserted at MUL iteration 4 -> next cycle IDLE, rsp_valid=0, cmd_ready=1; following ADD 2+3 -> 0x05. With ALU_ISSUE_STICKY_OVF_EN: overflow ADD sets ovf_sticky, ovf_clr clears it.
